// File: rtl/rv32_pkg.sv
// Shared RV32 constants: opcodes, field positions, register address width.
// Also holds the decode helpers used by writeback.
package rv32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int RD_LSB     = 7;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Destination register field of an instruction word
  function automatic reg_addr_t rd_of(input logic [31:0] ins);
    return ins[RD_LSB +: REG_ADDR_W];
  endfunction

  // Stores and branches never write rd; rd == x0 is never written
  function automatic logic writes_rd(input logic [31:0] ins);
    logic [6:0] opc;
    opc = ins[6:0];
    return (opc != OPC_STORE) && (opc != OPC_BRANCH) &&
           (rd_of(ins) != '0);
  endfunction

endpackage

// File: rtl/reg_array.sv
// 31-entry integer register array, one write port, two read ports.
// x0 has no storage; reads of address 0 return 0.
module reg_array
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem_q [1:31];
  logic [XLEN-1:0] mem_d [1:31];

  // Next array contents: single write port, x0 ignored
  always_comb begin
    mem_d = mem_q;
    for (int i = 1; i < 32; i++) begin
      if (we && waddr == reg_addr_t'(i)) begin
        mem_d[i] = wdata;
      end
    end
  end

  // Array storage, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read ports with x0 hardwired to zero
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (raddr1 == reg_addr_t'(i)) rdata1 = mem_q[i];
      if (raddr2 == reg_addr_t'(i)) rdata2 = mem_q[i];
    end
  end

endmodule

// File: rtl/reg_wb.sv
// Writeback stage: decode rd, stage one write, commit to reg_array.
// Define REG_WB_BYPASS_EN to forward the staged write to the read ports.
module reg_wb
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [31:0]      ins_wb_in,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             wb_stall,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [CNT_W-1:0] wb_count
);

  logic            accept;
  logic            stage_we_q, stage_we_d;
  reg_addr_t       stage_rd_q, stage_rd_d;
  logic [XLEN-1:0] stage_data_q, stage_data_d;
  logic [CNT_W-1:0] wb_count_q, wb_count_d;
  logic [XLEN-1:0] arr_rd1, arr_rd2;

  assign wb_ready = !wb_stall && !rst;
  assign accept   = wb_valid && wb_ready;
  assign wb_count = wb_count_q;

  // Stage load on accept; write-enable drops when nothing is accepted
  always_comb begin
    stage_we_d   = 1'b0;
    stage_rd_d   = stage_rd_q;
    stage_data_d = stage_data_q;
    if (accept) begin
      stage_we_d   = writes_rd(ins_wb_in);
      stage_rd_d   = rd_of(ins_wb_in);
      stage_data_d = wb_data;
    end
  end

  // Count each commit; wraps naturally
  always_comb begin
    wb_count_d = wb_count_q;
    if (stage_we_q) wb_count_d = wb_count_q + 1'b1;
  end

  // Stage and counter registers; reset drops any in-flight write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_we_q   <= 1'b0;
      stage_rd_q   <= '0;
      stage_data_q <= '0;
      wb_count_q   <= '0;
    end else begin
      stage_we_q   <= stage_we_d;
      stage_rd_q   <= stage_rd_d;
      stage_data_q <= stage_data_d;
      wb_count_q   <= wb_count_d;
    end
  end

  reg_array #(.XLEN(XLEN)) u_arr (
    .clk    (clk),
    .rst    (rst),
    .we     (stage_we_q),
    .waddr  (stage_rd_q),
    .wdata  (stage_data_q),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (arr_rd1),
    .rdata2 (arr_rd2)
  );

`ifdef REG_WB_BYPASS_EN
  // Forward the staged write ahead of its commit
  always_comb begin
    rs1_data = arr_rd1;
    rs2_data = arr_rd2;
    if (stage_we_q && rs1 == stage_rd_q && rs1 != '0)
      rs1_data = stage_data_q;
    if (stage_we_q && rs2 == stage_rd_q && rs2 != '0)
      rs2_data = stage_data_q;
  end
`else
  // Reads come straight from the array
  always_comb begin
    rs1_data = arr_rd1;
    rs2_data = arr_rd2;
  end
`endif

endmodule

// File: tb/tb_reg_wb.sv
// Randomized and directed bench for reg_wb against a register-file model.
// Expectations follow REG_WB_BYPASS_EN when it is defined.
module tb_reg_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] ins_wb_in;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] wb_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Architectural model: committed registers, pending writes, commit count
  logic [31:0] m_reg [32];
  logic [36:0] m_pend [$];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  reg_wb dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .ins_wb_in (ins_wb_in),
    .wb_data   (wb_data),
    .wb_stall  (wb_stall),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wb_count  (wb_count)
  );

  function automatic logic m_writes(input logic [31:0] ins);
    return ins[6:0] != 7'b0100011 && ins[6:0] != 7'b1100011 &&
           ins[11:7] != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'h0;
    v = m_reg[a];
`ifdef REG_WB_BYPASS_EN
    foreach (m_pend[i]) if (m_pend[i][36:32] == a) v = m_pend[i][31:0];
`endif
    return v;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_pend.delete();
    m_cnt = 32'h0;
  endfunction

  // One clock: commit what was staged, then stage this cycle's accept
  task automatic cyc();
    logic acc;
    acc = wb_valid && !wb_stall && !rst;
    @(posedge clk);
    if (rst) begin
      m_clear();
    end else begin
      if (m_pend.size() != 0) begin
        m_reg[m_pend[0][36:32]] = m_pend[0][31:0];
        m_cnt = m_cnt + 1;
        void'(m_pend.pop_front());
      end
      if (acc && m_writes(ins_wb_in))
        m_pend.push_back({ins_wb_in[11:7], wb_data});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    wb_stall = 1'b0;
    ins_wb_in = 32'h0;
    wb_data = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rs1 = 5'd5;
    rs2 = 5'd0;
    m_clear();
    cyc();
    cyc();
    chk_cnt++;
    if (wb_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", wb_ready);
    else pass_cnt++;
    chk_cnt++;
    if (wb_count !== 32'h0) $display("FAIL reset_count got %h want 0", wb_count);
    else pass_cnt++;
    chk_cnt++;
    if (rs1_data !== 32'h0) $display("FAIL reset_rs1 got %h want 0", rs1_data);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (wb_ready !== 1'b1) $display("FAIL ready_after_reset got %b want 1", wb_ready);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] exp1;
    wb_valid = 1'b1;
    ins_wb_in = 32'h00500293;
    wb_data = 32'hDEADBEEF;
    rs1 = 5'd5;
    cyc();
    idle();
`ifdef REG_WB_BYPASS_EN
    exp1 = 32'hDEADBEEF;
`else
    exp1 = 32'h0;
`endif
    chk_cnt++;
    if (rs1_data !== exp1) $display("FAIL wr_read_n got %h want %h", rs1_data, exp1);
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if (rs1_data !== 32'hDEADBEEF) $display("FAIL wr_read_n1 got %h want deadbeef", rs1_data);
    else pass_cnt++;
    chk_cnt++;
    if (wb_count !== 32'd1) $display("FAIL wr_count got %0d want 1", wb_count);
    else pass_cnt++;
  endtask

  task automatic test_no_write();
    logic [31:0] c0;
    logic [31:0] ins [3];
    ins[0] = 32'h0052A023;
    ins[1] = 32'h00528463;
    ins[2] = 32'h00000013 | 32'h12300000;
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1;
      ins_wb_in = ins[i];
      wb_data = (i == 2) ? 32'h12345678 : 32'hFFFFFFFF;
      cyc();
    end
    idle();
    cyc();
    rs1 = 5'd5;
    rs2 = 5'd0;
    #1;
    chk_cnt++;
    if (rs1_data !== 32'hDEADBEEF) $display("FAIL nowr_x5 got %h want deadbeef", rs1_data);
    else pass_cnt++;
    chk_cnt++;
    if (rs2_data !== 32'h0) $display("FAIL x0_read got %h want 0", rs2_data);
    else pass_cnt++;
    chk_cnt++;
    if (wb_count !== c0) $display("FAIL nowr_count got %0d want %0d", wb_count, c0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] c0;
    c0 = m_cnt;
    rs1 = 5'd7;
    rs2 = 5'd7;
    wb_valid = 1'b1;
    ins_wb_in = 32'h00100393;
    wb_data = 32'h1;
    cyc();
`ifdef REG_WB_BYPASS_EN
    chk_cnt++;
    if (rs1_data !== 32'h1) $display("FAIL b2b_mid1 got %h want 1", rs1_data);
    else pass_cnt++;
`endif
    ins_wb_in = 32'h00200393;
    wb_data = 32'h2;
    cyc();
    idle();
`ifdef REG_WB_BYPASS_EN
    chk_cnt++;
    if (rs2_data !== 32'h2) $display("FAIL b2b_mid2 got %h want 2", rs2_data);
    else pass_cnt++;
`endif
    cyc();
    cyc();
    chk_cnt++;
    if (rs1_data !== 32'h2) $display("FAIL b2b_final got %h want 2", rs1_data);
    else pass_cnt++;
    chk_cnt++;
    if (wb_count - c0 !== 32'd2) $display("FAIL b2b_count got %0d want %0d", wb_count, c0 + 2);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    c0 = m_cnt;
    rs1 = 5'd3;
    rs2 = 5'd4;
    wb_valid = 1'b1;
    ins_wb_in = 32'h0A500193;
    wb_data = 32'hA5A5A5A5;
    cyc();
    wb_stall = 1'b1;
    ins_wb_in = 32'h00100213;
    wb_data = 32'h44444444;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++;
      if (wb_ready !== 1'b0) $display("FAIL stall_ready[%0d] got %b want 0", i, wb_ready);
      else pass_cnt++;
      cyc();
    end
    idle();
    cyc();
    chk_cnt++;
    if (rs1_data !== 32'hA5A5A5A5) $display("FAIL stall_commit got %h want a5a5a5a5", rs1_data);
    else pass_cnt++;
    chk_cnt++;
    if (rs2_data !== 32'h0) $display("FAIL stall_noacc got %h want 0", rs2_data);
    else pass_cnt++;
    chk_cnt++;
    if (wb_count - c0 !== 32'd1) $display("FAIL stall_count got %0d want %0d", wb_count, c0 + 1);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [6:0] opcs [5];
    opcs[0] = 7'b0010011;
    opcs[1] = 7'b0100011;
    opcs[2] = 7'b1100011;
    opcs[3] = 7'b0110111;
    opcs[4] = 7'b0110011;
    for (int n = 0; n < 300; n++) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      wb_stall = ($urandom_range(0, 4) == 0);
      ins_wb_in = {$urandom_range(0, 32'hFFFFF),
                   5'($urandom_range(0, 31)),
                   opcs[$urandom_range(0, 4)]};
      wb_data = $urandom;
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      #1;
      chk_cnt++;
      if (wb_ready !== !wb_stall) $display("FAIL rnd_ready[%0d] got %b want %b", n, wb_ready, !wb_stall);
      else pass_cnt++;
      cyc();
      chk_cnt++;
      if (rs1_data !== m_read(rs1)) $display("FAIL rnd_rs1[%0d] x%0d got %h want %h", n, rs1, rs1_data, m_read(rs1));
      else pass_cnt++;
      chk_cnt++;
      if (rs2_data !== m_read(rs2)) $display("FAIL rnd_rs2[%0d] x%0d got %h want %h", n, rs2, rs2_data, m_read(rs2));
      else pass_cnt++;
      chk_cnt++;
      if (wb_count !== m_cnt) $display("FAIL rnd_count[%0d] got %0d want %0d", n, wb_count, m_cnt);
      else pass_cnt++;
    end
    idle();
    cyc();
  endtask

  task automatic test_reset_mid();
    wb_valid = 1'b1;
    ins_wb_in = 32'h07700493;
    wb_data = 32'h99999999;
    rs1 = 5'd9;
    rs2 = 5'd9;
    cyc();
    idle();
    rst = 1'b1;
    m_clear();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_cnt++;
      if (wb_ready !== 1'b0) $display("FAIL rmid_ready[%0d] got %b want 0", i, wb_ready);
      else pass_cnt++;
      chk_cnt++;
      if (rs1_data !== 32'h0) $display("FAIL rmid_x9[%0d] got %h want 0", i, rs1_data);
      else pass_cnt++;
      chk_cnt++;
      if (wb_count !== 32'h0) $display("FAIL rmid_count[%0d] got %0d want 0", i, wb_count);
      else pass_cnt++;
      wb_valid = 1'b1;
      cyc();
      #1;
    end
    idle();
    rst = 1'b0;
    cyc();
    cyc();
    chk_cnt++;
    if (rs2_data !== 32'h0) $display("FAIL rmid_x9_after got %h want 0", rs2_data);
    else pass_cnt++;
    chk_cnt++;
    if (wb_count !== 32'h0) $display("FAIL rmid_count_after got %0d want 0", wb_count);
    else pass_cnt++;
    chk_cnt++;
    if (wb_ready !== 1'b1) $display("FAIL rmid_ready_after got %b want 1", wb_ready);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    rs1 = 5'd0;
    rs2 = 5'd0;
    idle();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_no_write();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
